// File: rtl/ibex_xif_pkg.sv
// Shared ibex-xif types: multdiv operator encoding and the iterative multdiv FSM states.
package ibex_xif_pkg;

    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAbs  = 3'd1,
        StComp = 3'd2,
        StSign = 3'd3,
        StDone = 3'd4
    } md_iter_state_e;

    localparam int unsigned MD_ITER_MAX_WIDTH = 64;

endpackage

// File: rtl/ibex_xif_multdiv_negate.sv
// Two's-complement negator with enable; passes the input through when disabled.
module ibex_xif_multdiv_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    assign o_data = i_en ? (~i_data + WIDTH'(1)) : i_data;

endmodule

// File: rtl/ibex_xif_multdiv_iter.sv
// Iterative radix-2 multiplier/divider with valid/ready on both sides.
// Optional abort input kill_i is enabled by defining IBEX_XIF_MULTDIV_KILL_EN.
module ibex_xif_multdiv_iter
    import ibex_xif_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  md_op_e           operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o
`ifdef IBEX_XIF_MULTDIV_KILL_EN
    ,
    input  logic             kill_i
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_iter_state_e     r_state, w_state_d;
    md_op_e             r_op, w_op_d;
    logic               r_sign_a, w_sign_a_d;
    logic               r_sign_b, w_sign_b_d;
    logic               r_div_by_zero, w_div_by_zero_d;
    logic [WIDTH-1:0]   r_op_a, w_op_a_d;
    logic [WIDTH-1:0]   r_op_b, w_op_b_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic [2*WIDTH:0]   r_acc, w_acc_d;
    logic [WIDTH-1:0]   r_opnd, w_opnd_d;
    logic [WIDTH-1:0]   r_result, w_result_d;

    logic               w_kill;
    logic               w_is_mul;
    logic [WIDTH-1:0]   w_abs_a, w_abs_b;
    logic [WIDTH+1:0]   w_add_a, w_add_b, w_sum;
    logic               w_ge;
    logic               w_neg_en;
    logic [2*WIDTH-1:0] w_neg_in, w_neg_out;
    logic               w_unused_acc_msb;

`ifdef IBEX_XIF_MULTDIV_KILL_EN
    assign w_kill = kill_i;
`else
    assign w_kill = 1'b0;
`endif

    assign w_is_mul         = (r_op == MD_OP_MULL) || (r_op == MD_OP_MULH);
    assign w_unused_acc_msb = r_acc[2*WIDTH];

    ibex_xif_multdiv_negate #(.WIDTH(WIDTH)) u_neg_a (
        .i_en   (r_sign_a),
        .i_data (r_op_a),
        .o_data (w_abs_a)
    );

    ibex_xif_multdiv_negate #(.WIDTH(WIDTH)) u_neg_b (
        .i_en   (r_sign_b),
        .i_data (r_op_b),
        .o_data (w_abs_b)
    );

    // Shared adder: MUL adds the gated multiplicand to the upper product half,
    // DIV subtracts the divisor from the shifted partial remainder.
    assign w_add_a = w_is_mul ? {2'b00, r_acc[2*WIDTH-1:WIDTH]}
                              : {1'b0, r_acc[2*WIDTH-1:WIDTH-1]};
    assign w_add_b = w_is_mul ? {2'b00, (r_acc[0] ? r_opnd : '0)}
                              : {2'b11, ~r_opnd};
    assign w_sum   = w_add_a + w_add_b + {{(WIDTH+1){1'b0}}, ~w_is_mul};
    assign w_ge    = ~w_sum[WIDTH+1];

    always_comb begin
        w_neg_in = r_acc[2*WIDTH-1:0];
        w_neg_en = 1'b0;
        unique case (r_op)
            MD_OP_MULL, MD_OP_MULH: begin
                w_neg_in = r_acc[2*WIDTH-1:0];
                w_neg_en = r_sign_a ^ r_sign_b;
            end
            MD_OP_DIV: begin
                w_neg_in = {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
                w_neg_en = (r_sign_a ^ r_sign_b) & ~r_div_by_zero;
            end
            MD_OP_REM: begin
                w_neg_in = {{WIDTH{1'b0}}, r_acc[2*WIDTH-1:WIDTH]};
                w_neg_en = r_sign_a;
            end
            default: ;
        endcase
    end

    ibex_xif_multdiv_negate #(.WIDTH(2*WIDTH)) u_neg_res (
        .i_en   (w_neg_en),
        .i_data (w_neg_in),
        .o_data (w_neg_out)
    );

    always_comb begin
        w_state_d       = r_state;
        w_op_d          = r_op;
        w_sign_a_d      = r_sign_a;
        w_sign_b_d      = r_sign_b;
        w_div_by_zero_d = r_div_by_zero;
        w_op_a_d        = r_op_a;
        w_op_b_d        = r_op_b;
        w_cnt_d         = r_cnt;
        w_acc_d         = r_acc;
        w_opnd_d        = r_opnd;
        w_result_d      = r_result;

        unique case (r_state)
            StIdle: begin
                if (in_valid_i && !w_kill) begin
                    w_op_d     = operator_i;
                    w_op_a_d   = op_a_i;
                    w_op_b_d   = op_b_i;
                    w_sign_a_d = op_a_i[WIDTH-1] & signed_mode_i[0];
                    w_sign_b_d = op_b_i[WIDTH-1] & signed_mode_i[1];
                    if (!data_ind_timing_i && (op_b_i == '0)) begin
                        w_state_d = StDone;
                        unique case (operator_i)
                            MD_OP_MULL, MD_OP_MULH: w_result_d = '0;
                            MD_OP_DIV:              w_result_d = '1;
                            MD_OP_REM:              w_result_d = op_a_i;
                            default:                w_result_d = '0;
                        endcase
                    end else begin
                        w_state_d = StAbs;
                    end
                end
            end
            StAbs: begin
                // MUL keeps the multiplier in the low half; DIV keeps the dividend there.
                w_acc_d         = {{(WIDTH+1){1'b0}}, (w_is_mul ? w_abs_b : w_abs_a)};
                w_opnd_d        = w_is_mul ? w_abs_a : w_abs_b;
                w_div_by_zero_d = (r_op_b == '0);
                w_cnt_d         = CNT_W'(WIDTH-1);
                w_state_d       = StComp;
            end
            StComp: begin
                if (w_is_mul) begin
                    w_acc_d = {1'b0, w_sum[WIDTH:0], r_acc[WIDTH-1:1]};
                end else begin
                    w_acc_d = {(w_ge ? w_sum[WIDTH:0] : r_acc[2*WIDTH-1:WIDTH-1]),
                               r_acc[WIDTH-2:0], w_ge};
                end
                if (r_cnt == '0) begin
                    w_state_d = StSign;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            StSign: begin
                w_result_d = (r_op == MD_OP_MULH) ? w_neg_out[2*WIDTH-1:WIDTH]
                                                  : w_neg_out[WIDTH-1:0];
                w_state_d  = StDone;
            end
            StDone: begin
                if (out_ready_i) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_kill && (r_state != StIdle)) begin
            w_state_d = StIdle;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= StIdle;
            r_op          <= MD_OP_MULL;
            r_sign_a      <= 1'b0;
            r_sign_b      <= 1'b0;
            r_div_by_zero <= 1'b0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_opnd        <= '0;
            r_result      <= '0;
        end else begin
            r_state       <= w_state_d;
            r_op          <= w_op_d;
            r_sign_a      <= w_sign_a_d;
            r_sign_b      <= w_sign_b_d;
            r_div_by_zero <= w_div_by_zero_d;
            r_op_a        <= w_op_a_d;
            r_op_b        <= w_op_b_d;
            r_cnt         <= w_cnt_d;
            r_acc         <= w_acc_d;
            r_opnd        <= w_opnd_d;
            r_result      <= w_result_d;
        end
    end

    assign in_ready_o  = (r_state == StIdle);
    assign out_valid_o = (r_state == StDone);
    assign result_o    = r_result;

    a_state_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        r_state inside {StIdle, StAbs, StComp, StSign, StDone});
    a_result_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (out_valid_o && !out_ready_i) |=> $stable(result_o));
    a_ready_valid_excl: assert property (@(posedge clk_i)
        !(in_ready_o && out_valid_o));

endmodule

// File: tb/tb_ibex_xif_multdiv_iter.sv
// Self-checking bench for ibex_xif_multdiv_iter (WIDTH=32): directed corners plus random ops.
module tb_ibex_xif_multdiv_iter;
    import ibex_xif_pkg::*;

    localparam int W       = 32;
    localparam int LAT_STD = W + 3;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    md_op_e       operator_i = MD_OP_MULL;
    logic [1:0]   signed_mode_i = 2'b00;
    logic [W-1:0] op_a_i = '0;
    logic [W-1:0] op_b_i = '0;
    logic         data_ind_timing_i = 1'b0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] result_o;
`ifdef IBEX_XIF_MULTDIV_KILL_EN
    logic         kill_i = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    ibex_xif_multdiv_iter #(.WIDTH(W)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .in_valid_i        (in_valid_i),
        .in_ready_o        (in_ready_o),
        .operator_i        (operator_i),
        .signed_mode_i     (signed_mode_i),
        .op_a_i            (op_a_i),
        .op_b_i            (op_b_i),
        .data_ind_timing_i (data_ind_timing_i),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .result_o          (result_o)
`ifdef IBEX_XIF_MULTDIV_KILL_EN
        ,
        .kill_i            (kill_i)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Architectural result from plain integer arithmetic (truncating division).
    function automatic logic [W-1:0] ref_model(input md_op_e op, input logic [1:0] sm,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        longint      av, bv;
        logic [63:0] r;
        av = sm[0] ? longint'($signed(a)) : longint'({32'b0, a});
        bv = sm[1] ? longint'($signed(b)) : longint'({32'b0, b});
        case (op)
            MD_OP_MULL: begin r = av * bv; return r[31:0];  end
            MD_OP_MULH: begin r = av * bv; return r[63:32]; end
            MD_OP_DIV: begin
                if (b == '0) return '1;
                r = av / bv;
                return r[31:0];
            end
            default: begin
                if (b == '0) return a;
                r = av % bv;
                return r[31:0];
            end
        endcase
    endfunction

    // Issue one request, measure latency, optionally hold off the result, then consume it.
    task automatic run_op(input string tag, input md_op_e op, input logic [1:0] sm,
                          input logic [W-1:0] a, input logic [W-1:0] b, input logic dit,
                          input logic [W-1:0] exp_res, input int exp_lat, input int hold);
        int lat;
        check_eq({tag, ":rdy"}, 64'(in_ready_o), 64'd1);
        operator_i        = op;
        signed_mode_i     = sm;
        op_a_i            = a;
        op_b_i            = b;
        data_ind_timing_i = dit;
        in_valid_i        = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i        = 1'b0;
        operator_i        = md_op_e'($urandom_range(0, 3));
        signed_mode_i     = 2'($urandom);
        op_a_i            = $urandom;
        op_b_i            = $urandom;
        data_ind_timing_i = 1'($urandom);
        lat = 1;
        while (!out_valid_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check_eq({tag, ":lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, ":res"}, 64'(result_o), 64'(exp_res));
        for (int k = 0; k < hold; k++) begin
            in_valid_i = 1'b1;
            @(posedge clk_i);
            #1;
            check_eq({tag, ":hold_res"}, 64'(result_o), 64'(exp_res));
            check_eq({tag, ":hold_rdy"}, 64'(in_ready_o), 64'd0);
            check_eq({tag, ":hold_vld"}, 64'(out_valid_o), 64'd1);
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check_eq({tag, ":post_vld"}, 64'(out_valid_o), 64'd0);
    endtask

    initial begin
        md_op_e       op;
        logic [1:0]   sm;
        logic [W-1:0] a, b;
        logic         dit;
        int           sel;

        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_eq("reset_rdy", 64'(in_ready_o), 64'd1);
        check_eq("reset_vld", 64'(out_valid_o), 64'd0);
        check_eq("reset_res", 64'(result_o), 64'd0);

        run_op("mull_neg", MD_OP_MULL, 2'b11, 32'hFFFF_FFFD, 32'd7, 1'b0,
               32'hFFFF_FFEB, LAT_STD, 0);
        run_op("mulhu_max", MD_OP_MULH, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               32'hFFFF_FFFE, LAT_STD, 0);
        run_op("mulh_m1", MD_OP_MULH, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0,
               32'h0000_0000, LAT_STD, 0);
        run_op("div_ovf", MD_OP_DIV, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
               32'h8000_0000, LAT_STD, 0);
        run_op("rem_ovf", MD_OP_REM, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
               32'h0000_0000, LAT_STD, 0);
        run_op("div0_early", MD_OP_DIV, 2'b11, 32'd5, 32'd0, 1'b0,
               32'hFFFF_FFFF, 1, 0);
        run_op("rem0_dit", MD_OP_REM, 2'b11, 32'd5, 32'd0, 1'b1,
               32'd5, LAT_STD, 0);
        run_op("div0_neg_dit", MD_OP_DIV, 2'b11, 32'hFFFF_FFF6, 32'd0, 1'b1,
               32'hFFFF_FFFF, LAT_STD, 0);
        run_op("rem_neg", MD_OP_REM, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0,
               32'hFFFF_FFFF, LAT_STD, 0);
        run_op("divu_bp", MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1'b0,
               32'd14, LAT_STD, 10);

        // Reset in the middle of an iteration.
        operator_i = MD_OP_DIV;
        signed_mode_i = 2'b00;
        op_a_i = 32'd1000;
        op_b_i = 32'd3;
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_eq("rst_mid_rdy", 64'(in_ready_o), 64'd1);
        check_eq("rst_mid_vld", 64'(out_valid_o), 64'd0);
        check_eq("rst_mid_res", 64'(result_o), 64'd0);
        begin
            int seen = 0;
            repeat (40) begin
                @(posedge clk_i);
                #1;
                seen += int'(out_valid_o);
            end
            check_eq("rst_mid_no_vld", 64'(seen), 64'd0);
        end
        run_op("after_rst", MD_OP_MULL, 2'b00, 32'd12345, 32'd678, 1'b0,
               32'd8369910, LAT_STD, 0);

`ifdef IBEX_XIF_MULTDIV_KILL_EN
        begin
            int seen = 0;
            operator_i = MD_OP_MULL;
            op_a_i = 32'd9;
            op_b_i = 32'd9;
            in_valid_i = 1'b1;
            @(posedge clk_i);
            #1;
            in_valid_i = 1'b0;
            repeat (9) @(posedge clk_i);
            #1;
            kill_i = 1'b1;
            @(posedge clk_i);
            #1;
            kill_i = 1'b0;
            check_eq("kill_rdy", 64'(in_ready_o), 64'd1);
            check_eq("kill_vld", 64'(out_valid_o), 64'd0);
            repeat (40) begin
                @(posedge clk_i);
                #1;
                seen += int'(out_valid_o);
            end
            check_eq("kill_no_vld", 64'(seen), 64'd0);
            run_op("kill_divu", MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1'b0,
                   32'd14, LAT_STD, 0);
        end
`endif

        for (int i = 0; i < 300; i++) begin
            op  = md_op_e'($urandom_range(0, 3));
            sm  = 2'($urandom);
            a   = $urandom;
            b   = $urandom;
            dit = 1'($urandom);
            sel = $urandom_range(0, 15);
            if (sel == 0) b = '0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 20));
            if (sel == 3) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
            if (sel == 4) a = 32'($urandom_range(0, 100));
            run_op("rand", op, sm, a, b, dit, ref_model(op, sm, a, b),
                   (!dit && b == '0) ? 1 : LAT_STD, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ibex_xif_multdiv_iter.md
# ibex_xif_multdiv_iter

Parametrised, self-contained iterative multiplier/divider for the ibex-xif execute stage. It supersedes the ALU-sharing slow multdiv and adds:
- its own adder, so there is no operand muxing into the ALU;
- a `WIDTH` parameter;
- valid/ready handshakes on both sides, with the result held until consumed;
- an optional kill.

It produces one result bit per cycle (radix-2) using a unified magnitude-then-sign-fix datapath for all four operations.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; legal range 8..64.
- `CNT_W`, `$clog2(WIDTH)`: iteration counter width (localparam, not overridable).

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `in_valid_i` in 1: request valid.
- `in_ready_o` out 1: block can accept a request.
- `operator_i` in `md_op_e`: one of `MD_OP_MULL`, `MD_OP_MULH`, `MD_OP_DIV`, `MD_OP_REM`.
- `signed_mode_i` in 2: bit 0 = `op_a` is signed; bit 1 = `op_b` is signed.
- `op_a_i` in `WIDTH`: multiplicand / dividend.
- `op_b_i` in `WIDTH`: multiplier / divisor.
- `data_ind_timing_i` in 1: disables all early-out paths.
- `out_valid_o` out 1: result valid.
- `out_ready_i` in 1: consumer accepts the result.
- `result_o` out `WIDTH`: result; stable while `out_valid_o` is high.
- `kill_i` in 1: abort. Present only with `IBEX_XIF_MULTDIV_KILL_EN`.

## Operation
- A request is accepted on `in_valid_i && in_ready_o`. Operator, sign modes, operands and `data_ind_timing_i` are registered at accept; later input changes have no effect.
- `sign_a = op_a[W-1] & signed_mode[0]`; `sign_b = op_b[W-1] & signed_mode[1]`.
- FSM states: `IDLE`, `ABS`, `COMP`, `SIGN`, `DONE`.
  - `IDLE`:
    - `in_ready_o = 1`.
    - On accept, go to `ABS`.
    - Early-out: if `!data_ind_timing_i` and the result is trivial, go directly to `DONE` with the result loaded. Trivial cases are:
      - `op_b == 0` for MULL/MULH, giving result 0;
      - `op_b == 0` for DIV, giving all-ones;
      - `op_b == 0` for REM, giving `op_a`.
  - `ABS`:
    - `|a|` and `|b|` are formed with dedicated negators; the most-negative value maps to `2^(W-1)` unsigned.
    - `div_by_zero_q` is recorded.
    - Counter is set to `WIDTH-1`.
    - Go to `COMP`.
  - `COMP`, MUL: shift-add into a `2W+1`-bit accumulator, one multiplier bit per cycle.
  - `COMP`, DIV/REM:
    - Restoring long division: trial-subtract `|b|` from the partial remainder.
    - Set the quotient bit when the result is ≥ 0.
    - Shift in the next dividend bit.
  - `COMP` exit: counter decrements each cycle; after `WIDTH` iterations go to `SIGN`.
  - `SIGN`: conditionally negate the result:
    - MUL: the full 2W-bit product if `sign_a ^ sign_b`.
    - DIV: the quotient if `(sign_a ^ sign_b) & ~div_by_zero_q`.
    - REM: the remainder if `sign_a`.
    - Then go to `DONE`.
  - `DONE`: `out_valid_o = 1`; go to `IDLE` on `out_ready_i`.
- Result selection:
  - MULL: product bits `[W-1:0]`.
  - MULH: product bits `[2W-1:W]`.
  - DIV: quotient.
  - REM: remainder.
- Architectural corner cases are produced naturally by the datapath:
  - Division by 0: quotient all-ones, remainder `op_a`.
  - Signed overflow (`MIN / -1`): quotient `MIN`, remainder 0.
- Reset mid-operation: returns to `IDLE`, drops any held result, never emits a partial result.

## Timing
- Reset values:
  - `in_ready_o = 1`, `out_valid_o = 0`, `result_o = 0`.
  - State `IDLE`, all datapath registers 0.
- Normal latency: `out_valid_o` rises `WIDTH+3` cycles after the accept edge (`ABS` 1, `COMP` WIDTH, `SIGN` 1, `DONE` entry).
- Early-out latency: `out_valid_o` high in the cycle after accept.
- With `data_ind_timing_i = 1`, latency is `WIDTH+3` for every operand value.
- Backpressure: `DONE` holds indefinitely; `result_o` is stable and no new request is accepted. `in_ready_o` is high only in `IDLE`, so there is at least one bubble cycle between the output handshake and the next accept.
- No combinational path from `in_valid_i` or `out_ready_i` to any output.

## Configuration
- `IBEX_XIF_MULTDIV_KILL_EN` defined:
  - `kill_i` port exists.
  - `kill_i` high in any state other than `IDLE` forces `IDLE` on the next edge; `out_valid_o` is low from that edge.
  - `kill_i` takes priority over `out_ready_i` and over an accept in the same cycle: the request is not accepted.
- Not defined: no `kill_i` port; an operation always runs to `DONE`.

## Structure
- `md_op_e` is reused from `ibex_xif_pkg`.
- Add to `ibex_xif_pkg`:
  - `md_iter_state_e` (5 states, 3 bits);
  - localparam `MD_ITER_MAX_WIDTH = 64`.
- One sub-module, `ibex_xif_multdiv_negate`: parametrised two's-complement negator with an enable. It is instantiated for `|a|`, for `|b|`, and as a 2W-bit instance for the final sign fix.
- Assertions:
  - state is always one of the legal encodings;
  - `result_o` is stable while `out_valid_o && !out_ready_i`;
  - `in_ready_o` and `out_valid_o` are never both high.

## Test plan
1. `WIDTH=32`, MULL, signed 11, `a=-3`, `b=7`, `data_ind_timing=0` → `result 0xFFFF_FFEB`, valid at accept+35.
2. MULH, unsigned, `a=b=0xFFFF_FFFF` → `0xFFFF_FFFE`. Repeat with signed 11 → `0x0000_0000`.
3. DIV signed `0x8000_0000 / 0xFFFF_FFFF` → `0x8000_0000`; REM same operands → `0`.
4. DIV by 0 with `a=5`: `data_ind_timing=0` → `0xFFFF_FFFF` at accept+1. REM by 0 with `a=5`, `data_ind_timing=1` → `5` at accept+35.
5. `out_ready_i` low for 10 cycles in `DONE` → `result_o` stable and `in_ready_o` low throughout. Synchronous `rst_i` pulse mid-`COMP` → next cycle `in_ready_o=1`, `out_valid_o=0`.
6. With `IBEX_XIF_MULTDIV_KILL_EN`: `kill_i` at accept+10 → `IDLE` at accept+11 with no `out_valid_o`. A following DIVU `100/7` → `14`. Repeat at `WIDTH=16` and `WIDTH=64` with random ops against a reference model.
